// File: rtl/key_event_arbiter.sv
// key_event_arbiter: per-key sync/debounce/short-long press classification,
// round-robin merged onto one registered valid/ready event slot.
module key_event_arbiter #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_KEYS-1:0]         key_in,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(N_KEYS)-1:0] evt_key,
  output logic                      evt_long,
  output logic                      evt_drop
);
  localparam int KW = $clog2(N_KEYS);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, HELD, LONG_WAIT} state_t;
  logic [N_KEYS-1:0] w_pend, w_kind, w_post, w_gnt;
  logic [KW-1:0]     w_cand [N_KEYS];
  logic [KW-1:0]     w_idx;
  logic              w_any, w_load;
  logic              r_valid, r_long, r_drop;
  logic [KW-1:0]     r_key, r_ptr;
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic          r_s1, r_s2, r_deb, r_pend, r_kind;
    logic [DW-1:0] r_dcnt;
    logic [HW-1:0] r_hold;
    state_t        r_state;
    logic          w_long;
    assign w_long    = r_hold == HW'(LONG_CYCLES - 1);
    assign w_post[k] = (r_state == HELD) && (!r_deb || w_long);
    assign w_pend[k] = r_pend;
    assign w_kind[k] = r_kind;
    assign w_gnt[k]  = w_load && w_any && (w_idx == KW'(k));
    assign w_cand[k] = KW'((int'(r_ptr) + k) % N_KEYS);
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_deb   <= 1'b0;
        r_dcnt  <= '0;
        r_hold  <= '0;
        r_pend  <= 1'b0;
        r_kind  <= 1'b0;
        r_state <= IDLE;
      end else begin
        r_s1 <= key_in[k];
        r_s2 <= r_s1;
        if (r_s2 == r_deb) r_dcnt <= '0;
        else if (r_dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb  <= r_s2;
          r_dcnt <= '0;
        end else r_dcnt <= r_dcnt + DW'(1);
        case (r_state)
          IDLE: if (r_deb) begin
            r_state <= HELD;
            r_hold  <= HW'(1);
          end
          HELD: if (!r_deb) r_state <= IDLE;
          else begin
            r_hold <= r_hold + HW'(1);
            if (w_long) r_state <= LONG_WAIT;
          end
          LONG_WAIT: if (!r_deb) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
        // a post into an occupied slot survives only if that slot is granted now
        if (w_post[k] && (!r_pend || w_gnt[k])) begin
          r_pend <= 1'b1;
          r_kind <= r_deb;
        end else if (w_gnt[k]) r_pend <= 1'b0;
      end
    end
  end
  assign w_any  = |w_pend;
  assign w_load = !r_valid || evt_ready;
  always_comb begin
    w_idx = r_ptr;
    for (int i = N_KEYS - 1; i >= 0; i--)
      if (w_pend[w_cand[i]]) w_idx = w_cand[i];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_key   <= '0;
      r_long  <= 1'b0;
      r_drop  <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_drop <= |(w_post & w_pend & ~w_gnt);
      if (w_load) begin
        r_valid <= w_any;
        if (w_any) begin
          r_key  <= w_idx;
          r_long <= w_kind[w_idx];
          r_ptr  <= (w_idx == KW'(N_KEYS - 1)) ? '0 : w_idx + KW'(1);
        end
      end
    end
  end
  assign evt_valid = r_valid;
  assign evt_key   = r_key;
  assign evt_long  = r_long;
  assign evt_drop  = r_drop;
endmodule

// File: tb/tb_key_event_arbiter.sv
// tb_key_event_arbiter: directed latency/order/stall/reset scenarios plus a
// randomized run against a behavioural event model.
module tb_key_event_arbiter;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int L  = 16;
  localparam int KW = 2;
  logic          clk = 1'b0, rst_n = 1'b0, evt_ready = 1'b0;
  logic [N-1:0]  key_in = '0;
  logic          evt_valid, evt_long, evt_drop;
  logic [KW-1:0] evt_key;
  int total = 0, bad = 0, now = 0;
  int n_valid = 0, n_drop = 0, n_acc = 0, n_unstable = 0;
  bit [N-1:0] m_s1, m_s2, m_deb, m_pend, m_kind, m_ldone;
  int m_run [N];
  int m_press [N];
  bit m_valid, m_long, m_drop;
  int m_key, m_ptr;

  key_event_arbiter #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_key(evt_key), .evt_long(evt_long), .evt_drop(evt_drop)
  );

  always #5 clk = ~clk;

  // Model: presses are timestamped in the debounced domain; pending events
  // live in one slot per key and are handed out by a rotating scan.
  task automatic model_step();
    bit [N-1:0] post, plong;
    int g;
    now++;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_pend = '0; m_kind = '0; m_ldone = '0;
      m_valid = 0; m_long = 0; m_drop = 0; m_key = 0; m_ptr = 0;
      for (int k = 0; k < N; k++) begin m_run[k] = 0; m_press[k] = -1; end
      return;
    end
    post = '0; plong = '0;
    for (int k = 0; k < N; k++) begin
      if (m_press[k] >= 0) begin
        if (!m_deb[k]) begin post[k] = 1; m_press[k] = -1; end
        else if (now - m_press[k] == L - 1) begin
          post[k] = 1; plong[k] = 1; m_press[k] = -1; m_ldone[k] = 1;
        end
      end else if (m_ldone[k]) begin
        if (!m_deb[k]) m_ldone[k] = 0;
      end else if (m_deb[k]) m_press[k] = now;
    end
    if (!m_valid || evt_ready) begin
      g = -1;
      for (int i = 0; i < N && g < 0; i++) if (m_pend[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      m_valid = g >= 0;
      if (g >= 0) begin m_key = g; m_long = m_kind[g]; m_pend[g] = 0; m_ptr = (g + 1) % N; end
    end
    m_drop = |(post & m_pend);
    for (int k = 0; k < N; k++) if (post[k] && !m_pend[k]) begin m_pend[k] = 1; m_kind[k] = plong[k]; end
    for (int k = 0; k < N; k++) begin
      if (m_s2[k] != m_deb[k]) begin
        m_run[k]++;
        if (m_run[k] == D) begin m_deb[k] = m_s2[k]; m_run[k] = 0; end
      end else m_run[k] = 0;
    end
    m_s2 = m_s1;
    m_s1 = key_in;
  endtask

  task automatic tick();
    logic pv, pl;
    logic [KW-1:0] pk;
    pv = evt_valid && !evt_ready && rst_n;
    pk = evt_key;
    pl = evt_long;
    if (evt_valid && evt_ready && rst_n) n_acc++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (evt_valid) n_valid++;
    if (evt_drop) n_drop++;
    if (pv && rst_n && !(evt_valid && evt_key == pk && evt_long == pl)) n_unstable++;
  endtask

  task automatic pulse(input int k, input int hi, input int lo);
    key_in[k] = 1'b1;
    repeat (hi) tick();
    key_in[k] = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic test_reset();
    rst_n = 0; key_in = '0; evt_ready = 0;
    tick();
    total++;
    if ({evt_valid, evt_key, evt_long, evt_drop} !== '0)
      begin bad++; $display("FAIL reset_outputs: got %b want 0", {evt_valid, evt_key, evt_long, evt_drop}); end
    rst_n = 1;
    repeat (2) tick();
    total++;
    if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid: got %b want 0", evt_valid); end
  endtask

  task automatic test_short_press();
    int first = -1;
    logic [KW-1:0] k = '0;
    logic l = 1'b0;
    evt_ready = 1; n_valid = 0;
    key_in[1] = 1;
    repeat (10) tick();
    total++;
    if (n_valid !== 0) begin bad++; $display("FAIL short_no_event_on_press: got %0d want 0", n_valid); end
    key_in[1] = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (evt_valid && first < 0) begin first = i; k = evt_key; l = evt_long; end
    end
    total++;
    if (first !== D + 4) begin bad++; $display("FAIL short_latency: got %0d want %0d", first, D + 4); end
    total++;
    if (k !== 2'd1) begin bad++; $display("FAIL short_key: got %0d want 1", k); end
    total++;
    if (l !== 1'b0) begin bad++; $display("FAIL short_kind: got %b want 0", l); end
    total++;
    if (n_valid !== 1) begin bad++; $display("FAIL short_count: got %0d want 1", n_valid); end
  endtask

  task automatic test_long_press();
    int first = -1;
    logic [KW-1:0] k = '0;
    logic l = 1'b0;
    evt_ready = 1; n_valid = 0;
    key_in[2] = 1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (evt_valid && first < 0) begin first = i; k = evt_key; l = evt_long; end
    end
    key_in[2] = 0;
    repeat (20) tick();
    total++;
    if (first !== D + L + 3) begin bad++; $display("FAIL long_latency: got %0d want %0d", first, D + L + 3); end
    total++;
    if (k !== 2'd2) begin bad++; $display("FAIL long_key: got %0d want 2", k); end
    total++;
    if (l !== 1'b1) begin bad++; $display("FAIL long_kind: got %b want 1", l); end
    total++;
    if (n_valid !== 1) begin bad++; $display("FAIL long_count: got %0d want 1", n_valid); end
  endtask

  task automatic test_glitch();
    evt_ready = 1; n_valid = 0; n_drop = 0;
    pulse(0, 3, 12);
    for (int i = 0; i < 12; i++) begin
      key_in[0] = (i % 4) < 2;
      tick();
    end
    key_in[0] = 0;
    repeat (15) tick();
    total++;
    if (n_valid !== 0) begin bad++; $display("FAIL glitch_events: got %0d want 0", n_valid); end
    total++;
    if (n_drop !== 0) begin bad++; $display("FAIL glitch_drops: got %0d want 0", n_drop); end
  endtask

  task automatic test_back_to_back();
    logic [KW-1:0] q[$];
    int tq[$];
    int nl = 0;
    rst_n = 0; tick(); rst_n = 1;
    evt_ready = 1;
    key_in = 4'b1011;
    repeat (8) tick();
    key_in = '0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (evt_valid) begin q.push_back(evt_key); tq.push_back(i); if (evt_long) nl++; end
    end
    total++;
    if (q.size() != 3 || {q[0], q[1], q[2]} !== {2'd0, 2'd1, 2'd3})
      begin bad++; $display("FAIL rr_order_013: got n=%0d keys=%p want 0,1,3", q.size(), q); end
    total++;
    if (tq.size() != 3 || tq[2] - tq[0] != 2)
      begin bad++; $display("FAIL back_to_back_valid: got times=%p want 3 consecutive", tq); end
    total++;
    if (nl !== 0) begin bad++; $display("FAIL rr_kind: got %0d long events want 0", nl); end
    pulse(1, 8, 20);
    q.delete();
    key_in = 4'b1001;
    repeat (8) tick();
    key_in = '0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (evt_valid) q.push_back(evt_key);
    end
    total++;
    if (q.size() != 2 || {q[0], q[1]} !== {2'd3, 2'd0})
      begin bad++; $display("FAIL rr_wrap_30: got n=%0d keys=%p want 3,0", q.size(), q); end
  endtask

  task automatic test_stall();
    evt_ready = 0; n_drop = 0; n_unstable = 0; n_acc = 0;
    pulse(1, 8, 12);
    pulse(1, 8, 12);
    pulse(1, 8, 12);
    total++;
    if (n_drop !== 1) begin bad++; $display("FAIL stall_drop_pulses: got %0d want 1", n_drop); end
    total++;
    if (n_unstable !== 0) begin bad++; $display("FAIL stall_slot_stable: got %0d changes want 0", n_unstable); end
    total++;
    if ({evt_valid, evt_key, evt_long} !== {1'b1, 2'd1, 1'b0})
      begin bad++; $display("FAIL stall_slot: got %b want %b", {evt_valid, evt_key, evt_long}, {1'b1, 2'd1, 1'b0}); end
    evt_ready = 1;
    repeat (20) tick();
    total++;
    if (n_acc !== 2) begin bad++; $display("FAIL stall_accepted: got %0d want 2", n_acc); end
  endtask

  task automatic test_reset_mid();
    evt_ready = 0;
    pulse(1, 8, 12);
    pulse(2, 8, 12);
    total++;
    if (evt_valid !== 1'b1) begin bad++; $display("FAIL rstmid_setup_valid: got %b want 1", evt_valid); end
    rst_n = 0;
    tick();
    rst_n = 1;
    total++;
    if ({evt_valid, evt_key, evt_long, evt_drop} !== '0)
      begin bad++; $display("FAIL rstmid_outputs: got %b want 0", {evt_valid, evt_key, evt_long, evt_drop}); end
    evt_ready = 1; n_valid = 0;
    repeat (40) tick();
    total++;
    if (n_valid !== 0) begin bad++; $display("FAIL rstmid_no_event: got %0d want 0", n_valid); end
  endtask

  task automatic test_random();
    int cd [N];
    logic [KW+2:0] obs, exp;
    for (int k = 0; k < N; k++) cd[k] = $urandom_range(1, 30);
    n_unstable = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (cd[k] == 0) begin
          key_in[k] = ~key_in[k];
          cd[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
        end else cd[k]--;
      end
      evt_ready = (c % 500 < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rst_n = $urandom_range(0, 599) != 0;
      tick();
      exp = {m_valid, m_valid ? KW'(m_key) : KW'(0), m_valid & m_long, m_drop};
      obs = {evt_valid, evt_valid ? evt_key : KW'(0), evt_valid & evt_long, evt_drop};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL random_cycle_%0d: got valid/key/long/drop=%b want %b", now, obs, exp); end
    end
    rst_n = 1;
    total++;
    if (n_unstable !== 0) begin bad++; $display("FAIL random_slot_stable: got %0d changes want 0", n_unstable); end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_press();
    test_glitch();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
